// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-fed burst RAM: command encoding and read-control state.
// No logic; imported by the top level.
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port word RAM with a registered read port; array contents are never reset.
// Latency: read data valid the cycle after re; write lands on the same edge as we.
// Backpressure: none, one access per cycle, caller never issues we and re together.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Only the output register clears; it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_burst.sv
// Command-driven RAM: address/data writes and armed, auto-incrementing burst reads.
// Latency: read data and err both appear one cycle after the accepting edge.
// Backpressure: none, a command is taken every cycle rx_valid is high.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              err
);

    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] pay_addr;
    logic              pay_ok;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, mem_re, err_nxt;
    state_e            state, state_nxt;

    assign cmd     = cmd_e'(din[DATA_W+1:DATA_W]);
    assign payload = din[DATA_W-1:0];

    generate
        if (DATA_W >= ADDR_W) begin : g_slice
            assign pay_addr = payload[ADDR_W-1:0];
        end else begin : g_pad
            assign pay_addr = {{(ADDR_W-DATA_W){1'b0}}, payload};
        end
    endgenerate

    assign pay_ok = ({1'b0, pay_addr} < (ADDR_W+1)'(MEM_DEPTH));

    // Post-access increment wraps at the last populated word, not at 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] a);
        if (AUTO_INC == 0) begin
            return a;
        end else if (a == ADDR_W'(MEM_DEPTH - 1)) begin
            return '0;
        end else begin
            return a + ADDR_W'(1);
        end
    endfunction

    always_comb begin
        wr_addr_nxt = wr_addr;
        rd_addr_nxt = rd_addr;
        state_nxt   = state;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = rd_addr;
        err_nxt     = 1'b0;
        if (rx_valid) begin
            case (cmd)
                WR_ADDR: begin
                    if (pay_ok) wr_addr_nxt = pay_addr;
                    else        err_nxt     = 1'b1;
                end
                WR_DATA: begin
                    mem_we      = 1'b1;
                    mem_addr    = wr_addr;
                    wr_addr_nxt = bump(wr_addr);
                end
                RD_ADDR: begin
                    if (pay_ok) begin
                        rd_addr_nxt = pay_addr;
                        state_nxt   = ARMED;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (state == ARMED) begin
                        mem_re      = 1'b1;
                        rd_addr_nxt = bump(rd_addr);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_addr  <= '0;
            rd_addr  <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_addr  <= wr_addr_nxt;
            rd_addr  <= rd_addr_nxt;
            tx_valid <= mem_re;
            err      <= err_nxt;
        end
    end

    spi_ram_mem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we && !rst),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(payload),
        .rdata(dout)
    );

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench over three configurations: default, MEM_DEPTH=200, AUTO_INC=0.
// Stimulus queues the expected read/err event; a negedge monitor pops and compares.
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    typedef struct {
        bit         rd;
        bit         er;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid [3];
    logic [9:0] din      [3];
    logic [7:0] dout     [3];
    logic       tx_valid [3];
    logic       err      [3];

    exp_t q [3][$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) u0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .din(din[0]),
        .dout(dout[0]), .tx_valid(tx_valid[0]), .err(err[0]));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) u1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .din(din[1]),
        .dout(dout[1]), .tx_valid(tx_valid[1]), .err(err[1]));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) u2 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[2]), .din(din[2]),
        .dout(dout[2]), .tx_valid(tx_valid[2]), .err(err[2]));

    // Monitor: every output event must match the head of that instance's queue.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (tx_valid[d] || err[d]) begin
                n_vec++;
                if (q[d].size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out dut%0d: got tx=%0b err=%0b dout=%02h at cyc %0d, want no event",
                             d, tx_valid[d], err[d], dout[d], cyc);
                end else begin
                    exp_t e;
                    e = q[d].pop_front();
                    if (tx_valid[d] !== e.rd || err[d] !== e.er || cyc != e.cyc ||
                        (e.rd && dout[d] !== e.d)) begin
                        n_bad++;
                        $display("FAIL out dut%0d: got tx=%0b err=%0b dout=%02h cyc=%0d, want tx=%0b err=%0b dout=%02h cyc=%0d",
                                 d, tx_valid[d], err[d], dout[d], cyc, e.rd, e.er, e.d, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    task automatic send(input int d, input logic [1:0] c, input logic [7:0] pay,
                        input bit xr, input bit xe, input logic [7:0] xd);
        exp_t e;
        if (xr || xe) begin
            e.rd  = xr;
            e.er  = xe;
            e.d   = xd;
            e.cyc = cyc + 1;
            q[d].push_back(e);
        end
        rx_valid[d] = 1'b1;
        din[d]      = {c, pay};
        @(posedge clk); #1;
        rx_valid[d] = 1'b0;
    endtask

    task automatic cmd(input int d, input logic [1:0] c, input logic [7:0] pay);
        send(d, c, pay, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd(input int d, input logic [7:0] xd);
        send(d, RD_DATA, 8'h00, 1'b1, 1'b0, xd);
    endtask

    task automatic bad(input int d, input logic [1:0] c, input logic [7:0] pay);
        send(d, c, pay, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rx_valid[d] = 1'b0;
            din[d]      = '0;
        end
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_dout%0d", d), 32'(dout[d]), 32'h0);
            chk($sformatf("reset_tx%0d", d), 32'(tx_valid[d]), 32'h0);
            chk($sformatf("reset_err%0d", d), 32'(err[d]), 32'h0);
        end
        @(posedge clk); #1;

        // Unarmed read after reset: err only, dout stays 0.
        bad(0, RD_DATA, 8'h00);
        @(negedge clk);
        chk("unarmed_dout", 32'(dout[0]), 32'h0);
        @(posedge clk); #1;

        // Basic write then read.
        cmd(0, WR_ADDR, 8'h10);
        cmd(0, WR_DATA, 8'hA5);
        cmd(0, RD_ADDR, 8'h10);
        rd(0, 8'hA5);
        idle(1);

        // Burst across the 0xFF -> 0x00 wrap.
        cmd(0, WR_ADDR, 8'hFE);
        cmd(0, WR_DATA, 8'h11);
        cmd(0, WR_DATA, 8'h22);
        cmd(0, WR_DATA, 8'h33);
        cmd(0, RD_ADDR, 8'hFE);
        rd(0, 8'h11);
        rd(0, 8'h22);
        rd(0, 8'h33);
        idle(1);

        // Write immediately followed by read of the same word.
        cmd(0, RD_ADDR, 8'h40);
        cmd(0, WR_ADDR, 8'h40);
        cmd(0, WR_DATA, 8'h99);
        rd(0, 8'h99);
        idle(4);
        @(negedge clk);
        chk("dout_hold", 32'(dout[0]), 32'h99);
        @(posedge clk); #1;

        // MEM_DEPTH=200: out-of-range write address leaves wr_addr alone.
        cmd(1, WR_ADDR, 8'h20);
        bad(1, WR_ADDR, 8'hC8);
        cmd(1, WR_DATA, 8'h77);
        cmd(1, RD_ADDR, 8'h20);
        rd(1, 8'h77);
        // Wrap at 199 -> 0.
        cmd(1, WR_ADDR, 8'hC7);
        cmd(1, WR_DATA, 8'h01);
        cmd(1, WR_DATA, 8'h02);
        cmd(1, RD_ADDR, 8'hC7);
        rd(1, 8'h01);
        rd(1, 8'h02);
        // rd_addr now 0x01; a rejected RD_ADDR must not move it.
        cmd(1, WR_ADDR, 8'h01);
        cmd(1, WR_DATA, 8'h3C);
        bad(1, RD_ADDR, 8'hC8);
        rd(1, 8'h3C);
        idle(1);

        // AUTO_INC=0: both writes and both reads hit address 5.
        cmd(2, WR_ADDR, 8'h05);
        cmd(2, WR_DATA, 8'h5A);
        cmd(2, WR_DATA, 8'h6B);
        cmd(2, RD_ADDR, 8'h05);
        rd(2, 8'h6B);
        rd(2, 8'h6B);
        idle(1);

        // Read accepted in a reset cycle: reset wins, no tx_valid.
        rst         = 1'b1;
        rx_valid[0] = 1'b1;
        din[0]      = {RD_DATA, 8'h00};
        @(posedge clk); #1;
        rx_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_rd_tx", 32'(tx_valid[0]), 32'h0);
        chk("rst_rd_err", 32'(err[0]), 32'h0);
        chk("rst_rd_dout", 32'(dout[0]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Reset returned the FSM to IDLE.
        bad(0, RD_DATA, 8'h00);
        idle(3);

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pending_dut%0d", d), 32'(q[d].size()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 Parameter DATA_W, default 8: memory word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width in bits.
REQ-003 Parameter MEM_DEPTH, default 256: number of words; SHALL satisfy 1 <= MEM_DEPTH <= 2**ADDR_W.
REQ-004 Parameter AUTO_INC, default 1: 1 enables post-access address increment; 0 disables it.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 rx_valid  input  1  din carries a valid command this cycle.
REQ-009 din  input  DATA_W+2  din[DATA_W+1:DATA_W] is the command; din[DATA_W-1:0] is the payload.
REQ-010 dout  output  DATA_W  read data.
REQ-011 tx_valid  output  1  dout is valid this cycle.
REQ-012 err  output  1  one-cycle pulse flagging a rejected command.

Function
REQ-013 Commands SHALL be decoded only in cycles with rx_valid=1; rx_valid=0 SHALL change no state except clearing the tx_valid and err pulses.
REQ-014 Command 00 (WR_ADDR): wr_addr <= payload[ADDR_W-1:0] when that value < MEM_DEPTH; otherwise wr_addr is unchanged and err pulses.
REQ-015 Command 01 (WR_DATA): mem[wr_addr] <= payload; if AUTO_INC=1, wr_addr increments.
REQ-016 Command 10 (RD_ADDR): rd_addr <= payload[ADDR_W-1:0] and rd_armed <= 1 when that value < MEM_DEPTH; otherwise err pulses and rd_addr/rd_armed are unchanged.
REQ-017 Command 11 (RD_DATA) with rd_armed=1: on the next cycle dout <= mem[rd_addr] and tx_valid=1 for exactly one cycle; if AUTO_INC=1, rd_addr increments.
REQ-018 RD_DATA with rd_armed=0 SHALL NOT assert tx_valid and SHALL pulse err; dout holds.
REQ-019 Read latency: exactly 1 cycle from the RD_DATA accept edge to tx_valid high.
REQ-020 dout SHALL hold its last read value until the next successful RD_DATA.
REQ-021 Increments SHALL wrap from MEM_DEPTH-1 to 0 with no err.
REQ-022 err SHALL be high exactly 1 cycle after the offending command's accept edge, for one cycle.
REQ-023 Back-to-back RD_DATA on consecutive cycles SHALL produce tx_valid on consecutive cycles with consecutive addresses (AUTO_INC=1).
REQ-024 WR_DATA to address A followed next cycle by RD_DATA to A SHALL return the newly written value (write-first ordering across cycles).
REQ-025 Control is a 2-state FSM: IDLE (rd_armed=0) and ARMED (rd_armed=1). IDLE->ARMED on a valid RD_ADDR. ARMED persists through reads. Only rst returns the FSM to IDLE.

Reset
REQ-026 When rst=1 at a clock edge: dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, FSM=IDLE.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 rst SHALL take priority over any command in the same cycle; a read pending when rst asserts SHALL NOT produce tx_valid.

Structure
REQ-029 Package spi_ram_pkg SHALL hold the command enum typedef (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), the 2-bit command width constant and the FSM state typedef.
REQ-030 Storage SHALL be one sub-module, spi_ram_mem: single-port, synchronous read, parametrised by DATA_W/ADDR_W/MEM_DEPTH.

Verification (DATA_W=8, ADDR_W=8 unless stated)
REQ-031 WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_valid one cycle later, dout=0xA5, err=0.
REQ-032 Burst: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33; RD_ADDR 0xFE, three back-to-back RD_DATA -> dout 0x11, 0x22, 0x33 (addresses FE, FF, 00) on three consecutive tx_valid cycles.
REQ-033 After reset, RD_DATA without RD_ADDR -> err pulse, tx_valid=0, dout=0.
REQ-034 MEM_DEPTH=200: WR_ADDR 0xC8 -> err pulse, wr_addr unchanged; a following WR_DATA lands at the previous wr_addr.
REQ-035 AUTO_INC=0: RD_ADDR 0x05, two RD_DATA -> both return mem[0x05].
REQ-036 RD_DATA accepted in the same cycle rst=1 -> no tx_valid in the next cycle; all outputs 0.
